// File: rtl/flag_unit.sv
// Status-flag stage behind the ALU: architectural {N,V,C,Z} register, branch-condition
// evaluation on the registered flags, and a small LIFO for saving/restoring flags.
module flag_unit #(
   parameter int WIDTH       = 15,
   parameter int STACK_DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH:0]   alu_y_i,
   input  logic             alu_carry_i,
   input  logic             alu_overflow_i,
   input  logic             alu_zero_i,
   input  logic             we_flags_i,
   input  logic [2:0]       cond_i,
   input  logic             push_i,
   input  logic             pop_i,
   output logic [3:0]       flags_o,
   output logic             cond_true_o,
   output logic             stack_full_o,
   output logic             stack_empty_o,
   output logic             stack_err_o
);

   localparam int PW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [PW-1:0] SP_MAX = PW'(STACK_DEPTH);

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;

   typedef enum logic [2:0] {
      COND_AL = 3'b000,
      COND_EQ = 3'b001,
      COND_NE = 3'b010,
      COND_CS = 3'b011,
      COND_CC = 3'b100,
      COND_VS = 3'b101,
      COND_MI = 3'b110,
      COND_LT = 3'b111
   } cond_e;

   logic [3:0]    flags_q, flags_d;
   logic [PW-1:0] sp_q, sp_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          err_q, err_d;
   logic [3:0]    mem_q [0:STACK_DEPTH-1];

   logic          mem_we_s;
   logic          pop_ok_s;
   logic [PW-1:0] sp_dec_s;
   logic [IW-1:0] wr_idx_s;
   logic [IW-1:0] rd_idx_s;
   logic [3:0]    alu_flags_s;

   assign sp_dec_s    = sp_q - PW'(1);
   assign wr_idx_s    = sp_q[IW-1:0];
   assign rd_idx_s    = sp_dec_s[IW-1:0];
   assign alu_flags_s = {alu_y_i[WIDTH], alu_overflow_i, alu_carry_i, alu_zero_i};

   // Stack-op legality, pointer update and flags-register next state (pop beats we_flags).
   always_comb begin
      sp_d     = sp_q;
      err_d    = err_q;
      mem_we_s = 1'b0;
      pop_ok_s = 1'b0;
      if (push_i && pop_i) begin
         err_d = 1'b1;
      end else if (push_i) begin
         if (full_q) begin
            err_d = 1'b1;
         end else begin
            mem_we_s = 1'b1;
            sp_d     = sp_q + PW'(1);
         end
      end else if (pop_i) begin
         if (empty_q) begin
            err_d = 1'b1;
         end else begin
            pop_ok_s = 1'b1;
            sp_d     = sp_dec_s;
         end
      end else begin
         sp_d = sp_q;
      end

      if (pop_ok_s) begin
         flags_d = mem_q[rd_idx_s];
      end else if (we_flags_i) begin
         flags_d = alu_flags_s;
      end else begin
         flags_d = flags_q;
      end

      full_d  = (sp_d == SP_MAX);
      empty_d = (sp_d == PW'(0));
   end

   // Architectural state; reset wins over every other input on the same edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         flags_q <= 4'b0000;
         sp_q    <= PW'(0);
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         sp_q    <= sp_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   // Stack storage holds the flags value from before the pushing edge; never cleared.
   always_ff @(posedge clk_i) begin
      if (!reset_i && mem_we_s) begin
         mem_q[wr_idx_s] <= flags_q;
      end
   end

   // Branch condition evaluated against the registered flags only.
   always_comb begin
      case (cond_e'(cond_i))
         COND_AL: cond_true_o = 1'b1;
         COND_EQ: cond_true_o = flags_q[FLAG_Z];
         COND_NE: cond_true_o = ~flags_q[FLAG_Z];
         COND_CS: cond_true_o = flags_q[FLAG_C];
         COND_CC: cond_true_o = ~flags_q[FLAG_C];
         COND_VS: cond_true_o = flags_q[FLAG_V];
         COND_MI: cond_true_o = flags_q[FLAG_N];
         COND_LT: cond_true_o = flags_q[FLAG_N] ^ flags_q[FLAG_V];
         default: cond_true_o = 1'b0;
      endcase
   end

   assign flags_o       = flags_q;
   assign stack_full_o  = full_q;
   assign stack_empty_o = empty_q;
   assign stack_err_o   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: vector table for capture/condition/basic stack ops,
// hand-written sequences for overflow/underflow, illegal ops and mid-sequence reset.
module tb_flag_unit;

   logic        clk;
   logic        reset;
   logic [15:0] alu_y;
   logic        alu_carry;
   logic        alu_overflow;
   logic        alu_zero;
   logic        we_flags;
   logic [2:0]  cond;
   logic        push;
   logic        pop;
   logic [3:0]  flags;
   logic        cond_true;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;

   int n_cmp;
   int n_fail;

   flag_unit #(.WIDTH(15), .STACK_DEPTH(4)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .alu_y_i        (alu_y),
      .alu_carry_i    (alu_carry),
      .alu_overflow_i (alu_overflow),
      .alu_zero_i     (alu_zero),
      .we_flags_i     (we_flags),
      .cond_i         (cond),
      .push_i         (push),
      .pop_i          (pop),
      .flags_o        (flags),
      .cond_true_o    (cond_true),
      .stack_full_o   (stack_full),
      .stack_empty_o  (stack_empty),
      .stack_err_o    (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] y;
      logic        c;
      logic        v;
      logic        z;
      logic        push;
      logic        pop;
      logic [2:0]  cond;
      logic [3:0]  e_flags;
      logic        e_ct;
      logic        e_full;
      logic        e_empty;
      logic        e_err;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      we_flags     = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      alu_y        = 16'h0000;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      alu_zero     = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // drive ALU inputs so that the captured flags equal f = {N,V,C,Z}
   task automatic drive_alu(input logic [3:0] f);
      alu_y        = {f[3], 15'h1234};
      alu_overflow = f[2];
      alu_carry    = f[1];
      alu_zero     = f[0];
   endtask

   task automatic check_state(input string tag, input logic [3:0] ef, input logic efull,
                              input logic eempty, input logic eerr);
      check({tag, ".flags"}, {12'h000, flags}, {12'h000, ef});
      check({tag, ".full"},  {15'h0000, stack_full},  {15'h0000, efull});
      check({tag, ".empty"}, {15'h0000, stack_empty}, {15'h0000, eempty});
      check({tag, ".err"},   {15'h0000, stack_err},   {15'h0000, eerr});
   endtask

   logic [3:0] seq_f [5];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b0;
      cond   = 3'b000;
      idle_inputs();

      //            we    y         c     v     z     push  pop   cond    flags    ct    full  empty err
      vecs[0]  = '{1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};

      // reset state and condition decode on cleared flags
      do_reset();
      check_state("reset", 4'b0000, 1'b0, 1'b1, 1'b0);
      cond = 3'b000; #1;
      check("reset.cond_al", {15'h0000, cond_true}, 16'h0001);
      cond = 3'b001; #1;
      check("reset.cond_eq", {15'h0000, cond_true}, 16'h0000);

      // table-driven capture / condition / simple push-pop
      for (int i = 0; i < 12; i++) begin
         we_flags     = vecs[i].we;
         alu_y        = vecs[i].y;
         alu_carry    = vecs[i].c;
         alu_overflow = vecs[i].v;
         alu_zero     = vecs[i].z;
         push         = vecs[i].push;
         pop          = vecs[i].pop;
         cond         = vecs[i].cond;
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].e_flags, vecs[i].e_full,
                     vecs[i].e_empty, vecs[i].e_err);
         check($sformatf("vec%0d.cond_true", i), {15'h0000, cond_true}, {15'h0000, vecs[i].e_ct});
      end
      idle_inputs();

      // fill to depth, overflow push, then LIFO drain
      seq_f[0] = 4'h3; seq_f[1] = 4'h5; seq_f[2] = 4'h9; seq_f[3] = 4'hA; seq_f[4] = 4'hC;
      do_reset();
      we_flags = 1'b1; drive_alu(seq_f[0]);
      tick();
      for (int k = 1; k <= 4; k++) begin
         push = 1'b1; we_flags = 1'b1; drive_alu(seq_f[k]);
         tick();
         check_state($sformatf("fill%0d", k), seq_f[k], (k == 4), 1'b0, 1'b0);
      end
      idle_inputs();
      push = 1'b1;
      tick();
      idle_inputs();
      check_state("overflow", seq_f[4], 1'b1, 1'b0, 1'b1);
      tick();
      check_state("err_sticky", seq_f[4], 1'b1, 1'b0, 1'b1);
      for (int k = 3; k >= 0; k--) begin
         pop = 1'b1;
         tick();
         check_state($sformatf("drain%0d", k), seq_f[k], 1'b0, (k == 0), 1'b1);
      end
      idle_inputs();

      // pop on empty with we_flags still captures ALU flags
      do_reset();
      pop = 1'b1; we_flags = 1'b1; drive_alu(4'b0001);
      tick();
      idle_inputs();
      check_state("underflow", 4'b0001, 1'b0, 1'b1, 1'b1);

      // push+pop together is illegal and leaves the single entry in place
      do_reset();
      we_flags = 1'b1; drive_alu(4'b0110);
      tick();
      idle_inputs();
      push = 1'b1;
      tick();
      idle_inputs();
      check_state("push1", 4'b0110, 1'b0, 1'b0, 1'b0);
      push = 1'b1; pop = 1'b1;
      tick();
      idle_inputs();
      check_state("pushpop", 4'b0110, 1'b0, 1'b0, 1'b1);
      we_flags = 1'b1; drive_alu(4'b0000);
      tick();
      idle_inputs();
      pop = 1'b1;
      tick();
      idle_inputs();
      check_state("pushpop_pop", 4'b0110, 1'b0, 1'b1, 1'b1);

      // reset mid-sequence overrides a concurrent push
      do_reset();
      we_flags = 1'b1; drive_alu(4'b1011);
      tick();
      push = 1'b1;
      tick();
      tick();
      idle_inputs();
      check_state("two_pushed", 4'b1011, 1'b0, 1'b0, 1'b0);
      reset = 1'b1; push = 1'b1; we_flags = 1'b1; drive_alu(4'b1111);
      tick();
      reset = 1'b0;
      idle_inputs();
      check_state("mid_reset", 4'b0000, 1'b0, 1'b1, 1'b0);
      pop = 1'b1;
      tick();
      idle_inputs();
      check_state("post_reset_pop", 4'b0000, 1'b0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
